// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared UART definitions (state encoding, default baud divisor)
// Shared with the receiver. Macro UART_TX_PARITY_EN adds the PARITY state.
package uart_tx_pkg;
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif
    localparam int DEFAULT_CLKS_PER_BIT = 16;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: FWFT FIFO read port between transmit FIFO and uart_tx
// Signals: idata (head word), empty (FIFO empty), next (one-cycle pop strobe).
// master = FIFO side, slave = transmitter side.
interface uart_tx_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] idata;
    logic             empty;
    logic             next;
    modport master (output idata, empty, input next);
    modport slave  (input idata, empty, output next);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the UART transmitter
// Ports: clk, rst (sync, active-high), restart (hold counter at 0),
//        bit_done (high on the last cycle of each CLKS_PER_BIT period).
import uart_tx_pkg::*;
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt_q, cnt_d;
    assign bit_done = cnt_q == CW'(CLKS_PER_BIT - 1);
    always_comb cnt_d = (restart || bit_done) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter draining a FWFT FIFO
// Ports: clk, rst (sync, active-high), fifo (uart_tx_if.slave: idata/empty/next),
//        tx_o (registered serial line, idles high), busy_o (frame in progress).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
import uart_tx_pkg::*;
module uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  fifo,
    output logic      tx_o,
    output logic      busy_o
);
    localparam int BW = $clog2(WIDTH);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             tx_q, tx_d, next_q, next_d, busy_q, busy_d;
    logic             bit_done, load;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .restart  (state_q == IDLE),
        .bit_done (bit_done)
    );
    // empty is only looked at in IDLE and on the last stop cycle
    assign load = !fifo.empty && (state_q == IDLE || (state_q == STOP && bit_done));
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        next_d  = 1'b0;
        busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: tx_d = 1'b1;
            START: if (bit_done) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            DATA: if (bit_done) begin
                shift_d = shift_q >> 1;
                if (bit_q == BW'(WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d    = par_q;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_d = bit_q + 1'b1;
                    tx_d  = shift_q[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
`endif
            STOP: if (bit_done) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // a load overrides the IDLE/STOP decisions and starts a frame at once
        if (load) begin
            state_d = START;
            shift_d = fifo.idata;
            bit_d   = '0;
            tx_d    = 1'b0;
            next_d  = 1'b1;
            busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
            par_d   = ^fifo.idata;
`endif
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            next_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            next_q  <= next_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
    assign fifo.next = next_q;
    assign tx_o      = tx_q;
    assign busy_o    = busy_q;
endmodule
